// File: rtl/halut_pkg.sv
// HALUT shared types and sizing for the decoder datapath and its sequencer.
// Constants only; no logic, no latency, no flow control.
package halut_pkg;

  localparam int unsigned DecoderUnits  = 4;
  localparam int unsigned K             = 16;
  localparam int unsigned C             = 4;
  localparam int unsigned DataTypeWidth = 16;
  localparam int unsigned CtrlTimeout   = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FILL,
    ISSUE,
    COLLECT
  } ctrl_state_e;

endpackage

// File: rtl/halut_code_row_buf.sv
// One row of encoded prototype indices: sequential write with fill count, indexed read.
// Write lands next cycle, read is combinational; writes past C entries are dropped.
module halut_code_row_buf #(
  parameter int unsigned C          = 4,
  parameter int unsigned TreeDepth  = 4,
  localparam int unsigned CAddrWidth = $clog2(C),
  localparam int unsigned CntWidth   = $clog2(C + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  wr_en_i,
  input  logic [TreeDepth-1:0]  wr_data_i,
  input  logic [CAddrWidth-1:0] rd_idx_i,
  output logic [TreeDepth-1:0]  rd_data_o,
  output logic [CntWidth-1:0]   count_o
);

  logic [TreeDepth-1:0] mem_q [C];
  logic [CntWidth-1:0]  cnt_q;
  logic                 wr_ok;

  assign wr_ok = wr_en_i && !clr_i && (cnt_q < CntWidth'(C));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (wr_ok) begin
      cnt_q <= cnt_q + CntWidth'(1);
    end
  end

  // Payload needs no reset: it is only read after C fresh writes.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[cnt_q[CAddrWidth-1:0]] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];
  assign count_o   = cnt_q;

endmodule

// File: rtl/halut_decoder_ctrl.sv
// Sequencer for halut_decoder_x: LUT load, row code issue, result collection and tagging.
// Results appear 1 cycle after dec_valid_i; readies are pure state decodes; no result backpressure.
module halut_decoder_ctrl
  import halut_pkg::*;
#(
  parameter int unsigned DecoderUnits  = halut_pkg::DecoderUnits,
  parameter int unsigned K             = halut_pkg::K,
  parameter int unsigned C             = halut_pkg::C,
  parameter int unsigned DataTypeWidth = halut_pkg::DataTypeWidth,
  parameter int unsigned RowWidth      = 16,
  parameter int unsigned Timeout       = halut_pkg::CtrlTimeout,
  localparam int unsigned TotalAddrWidth = $clog2(C * K),
  localparam int unsigned CAddrWidth     = $clog2(C),
  localparam int unsigned TreeDepth      = $clog2(K),
  localparam int unsigned DecAddrWidth   = $clog2(DecoderUnits)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      load_i,
  input  logic [RowWidth-1:0]       rows_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  input  logic                      lut_valid_i,
  output logic                      lut_ready_o,
  input  logic [DataTypeWidth-1:0]  lut_data_i,
  input  logic                      code_valid_i,
  output logic                      code_ready_o,
  input  logic [TreeDepth-1:0]      code_i,
  output logic [DecAddrWidth-1:0]   dec_m_addr_o,
  output logic [TotalAddrWidth-1:0] dec_waddr_o,
  output logic [DataTypeWidth-1:0]  dec_wdata_o,
  output logic                      dec_we_o,
  output logic [CAddrWidth-1:0]     dec_c_addr_o,
  output logic [TreeDepth-1:0]      dec_k_addr_o,
  output logic                      dec_decoder_o,
  input  logic [31:0]               dec_result_i,
  input  logic                      dec_valid_i,
  input  logic [DecAddrWidth-1:0]   dec_m_addr_i,
  output logic                      res_valid_o,
  output logic [31:0]               res_data_o,
  output logic [RowWidth-1:0]       res_row_o,
  output logic [DecAddrWidth-1:0]   res_col_o
);

  localparam int unsigned CntWidth     = $clog2(C + 1);
  localparam int unsigned TimeoutWidth = $clog2(Timeout + 1);

  localparam logic [TotalAddrWidth-1:0] WaddrLast = TotalAddrWidth'(C * K - 1);
  localparam logic [DecAddrWidth-1:0]   UnitLast  = DecAddrWidth'(DecoderUnits - 1);
  localparam logic [CAddrWidth-1:0]     IssueLast = CAddrWidth'(C - 1);
  localparam logic [CntWidth-1:0]       FillLast  = CntWidth'(C - 1);
  localparam logic [TimeoutWidth-1:0]   IdleLast  = TimeoutWidth'(Timeout - 1);

  ctrl_state_e state_q, state_d;

  logic [RowWidth-1:0]       rows_q;
  logic [RowWidth-1:0]       row_q;
  logic [DecAddrWidth-1:0]   col_q;
  logic [DecAddrWidth-1:0]   m_q;
  logic [TotalAddrWidth-1:0] waddr_q;
  logic [CAddrWidth-1:0]     issue_q;
  logic [TimeoutWidth-1:0]   idle_q;
  logic                      err_q;
  logic                      done_q;
  logic                      res_valid_q;
  logic [31:0]               res_data_q;
  logic [RowWidth-1:0]       res_row_q;
  logic [DecAddrWidth-1:0]   res_col_q;

  logic                      lut_hs;
  logic                      code_hs;
  logic                      last_row;
  logic [TreeDepth-1:0]      buf_k;
  logic [CntWidth-1:0]       fill_cnt;

  assign last_row = (row_q == rows_q - RowWidth'(1));

  halut_code_row_buf #(
    .C         (C),
    .TreeDepth (TreeDepth)
  ) u_row_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (state_q != FILL),
    .wr_en_i   (code_hs),
    .wr_data_i (code_i),
    .rd_idx_i  (issue_q),
    .rd_data_o (buf_k),
    .count_o   (fill_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    lut_ready_o   = 1'b0;
    code_ready_o  = 1'b0;
    dec_decoder_o = 1'b0;
    dec_m_addr_o  = '0;
    dec_waddr_o   = '0;
    dec_c_addr_o  = '0;
    dec_k_addr_o  = '0;
    unique case (state_q)
      IDLE: begin
        if (start_i && (rows_i != '0)) begin
          state_d = load_i ? LOAD : FILL;
        end
      end
      LOAD: begin
        lut_ready_o  = 1'b1;
        dec_m_addr_o = m_q;
        dec_waddr_o  = waddr_q;
        if (lut_valid_i && (m_q == UnitLast) && (waddr_q == WaddrLast)) begin
          state_d = FILL;
        end
      end
      FILL: begin
        code_ready_o = 1'b1;
        if (code_valid_i && (fill_cnt == FillLast)) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        dec_decoder_o = 1'b1;
        dec_c_addr_o  = issue_q;
        dec_k_addr_o  = buf_k;
        if (issue_q == IssueLast) begin
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        dec_decoder_o = 1'b1;
        if (dec_valid_i) begin
          if (col_q == UnitLast) begin
            state_d = last_row ? IDLE : FILL;
          end
        end else if (idle_q == IdleLast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign lut_hs      = lut_valid_i && lut_ready_o;
  assign code_hs     = code_valid_i && code_ready_o;
  assign dec_we_o    = lut_hs;
  assign dec_wdata_o = lut_hs ? lut_data_i : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rows_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      m_q         <= '0;
      waddr_q     <= '0;
      issue_q     <= '0;
      idle_q      <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_row_q   <= '0;
      res_col_q   <= '0;
    end else begin
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            rows_q  <= rows_i;
            err_q   <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            m_q     <= '0;
            waddr_q <= '0;
            issue_q <= '0;
            idle_q  <= '0;
            done_q  <= (rows_i == '0);
          end
        end
        LOAD: begin
          if (lut_hs) begin
            if (waddr_q == WaddrLast) begin
              waddr_q <= '0;
              m_q     <= m_q + DecAddrWidth'(1);
            end else begin
              waddr_q <= waddr_q + TotalAddrWidth'(1);
            end
          end
        end
        ISSUE: begin
          issue_q <= (issue_q == IssueLast) ? '0 : issue_q + CAddrWidth'(1);
        end
        COLLECT: begin
          if (dec_valid_i) begin
            res_valid_q <= 1'b1;
            res_data_q  <= dec_result_i;
            res_row_q   <= row_q;
            res_col_q   <= col_q;
            col_q       <= col_q + DecAddrWidth'(1);
            idle_q      <= '0;
            // A unit answering out of order is flagged but still tagged by arrival slot.
            if (dec_m_addr_i != col_q) begin
              err_q <= 1'b1;
            end
            if (col_q == UnitLast) begin
              if (last_row) begin
                done_q <= 1'b1;
              end else begin
                row_q <= row_q + RowWidth'(1);
              end
            end
          end else if (idle_q == IdleLast) begin
            err_q  <= 1'b1;
            idle_q <= '0;
          end else begin
            idle_q <= idle_q + TimeoutWidth'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_row_o   = res_row_q;
  assign res_col_o   = res_col_q;

endmodule

// File: tb/tb_halut_decoder_ctrl.sv
// Directed bench for halut_decoder_ctrl with a behavioural decoder (LUT entry = write beat index).
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_halut_decoder_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i, load_i;
  logic [15:0] rows_i;
  logic        busy_o, done_o, err_o;
  logic        lut_valid_i, lut_ready_o;
  logic [15:0] lut_data_i;
  logic        code_valid_i, code_ready_o;
  logic [3:0]  code_i;
  logic [1:0]  dec_m_addr_o;
  logic [5:0]  dec_waddr_o;
  logic [15:0] dec_wdata_o;
  logic        dec_we_o;
  logic [1:0]  dec_c_addr_o;
  logic [3:0]  dec_k_addr_o;
  logic        dec_decoder_o;
  logic [31:0] dec_result_i;
  logic        dec_valid_i;
  logic [1:0]  dec_m_addr_i;
  logic        res_valid_o;
  logic [31:0] res_data_o;
  logic [15:0] res_row_o;
  logic [1:0]  res_col_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  halut_decoder_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .load_i(load_i), .rows_i(rows_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .lut_valid_i(lut_valid_i), .lut_ready_o(lut_ready_o), .lut_data_i(lut_data_i),
    .code_valid_i(code_valid_i), .code_ready_o(code_ready_o), .code_i(code_i),
    .dec_m_addr_o(dec_m_addr_o), .dec_waddr_o(dec_waddr_o), .dec_wdata_o(dec_wdata_o),
    .dec_we_o(dec_we_o), .dec_c_addr_o(dec_c_addr_o), .dec_k_addr_o(dec_k_addr_o),
    .dec_decoder_o(dec_decoder_o), .dec_result_i(dec_result_i), .dec_valid_i(dec_valid_i),
    .dec_m_addr_i(dec_m_addr_i), .res_valid_o(res_valid_o), .res_data_o(res_data_o),
    .res_row_o(res_row_o), .res_col_o(res_col_o)
  );

  logic [87:0] all_outs;
  assign all_outs = {lut_ready_o, code_ready_o, dec_m_addr_o, dec_waddr_o, dec_wdata_o,
                     dec_we_o, dec_c_addr_o, dec_k_addr_o, dec_decoder_o, res_valid_o,
                     res_data_o, res_row_o, res_col_o, busy_o, done_o, err_o};

  // Behavioural decoder: captures C issued pairs, waits 2 cycles, returns one sum per unit.
  bit          suppress = 1'b0;
  int          issue_n = 0, wait_n = 0, emit_m = 0;
  logic [1:0]  iss_c [4];
  logic [3:0]  iss_k [4];
  longint      emit_t [$];
  int unsigned acc;

  always @(negedge clk) begin
    dec_valid_i  = 1'b0;
    dec_m_addr_i = '0;
    dec_result_i = '0;
    if (!dec_decoder_o) begin
      issue_n = 0; wait_n = 0; emit_m = 0;
    end else if (issue_n < 4) begin
      iss_c[issue_n] = dec_c_addr_o;
      iss_k[issue_n] = dec_k_addr_o;
      issue_n++;
      wait_n = 2;
    end else if (wait_n > 0) begin
      wait_n--;
    end else if (emit_m < 4 && !suppress) begin
      acc = 0;
      for (int c = 0; c < 4; c++) acc += emit_m * 64 + int'(iss_c[c]) * 16 + int'(iss_k[c]);
      dec_valid_i  = 1'b1;
      dec_m_addr_i = 2'(emit_m);
      dec_result_i = acc;
      emit_t.push_back($time);
      emit_m++;
    end
  end

  // Output monitor.
  int          wr_cnt = 0, done_cnt = 0, rdy_cnt = 0, dec_hi_cnt = 0;
  logic [1:0]  last_m;
  logic [5:0]  last_waddr;
  logic [15:0] last_wdata;
  bit          done_ok;
  logic [31:0] r_data [$];
  logic [15:0] r_row  [$];
  logic [1:0]  r_col  [$];
  longint      r_t    [$];

  always @(negedge clk) begin
    if (dec_we_o) begin
      wr_cnt++; last_m = dec_m_addr_o; last_waddr = dec_waddr_o; last_wdata = dec_wdata_o;
    end
    if (code_ready_o) rdy_cnt++;
    if (dec_decoder_o) dec_hi_cnt++;
    if (res_valid_o) begin
      r_data.push_back(res_data_o); r_row.push_back(res_row_o);
      r_col.push_back(res_col_o); r_t.push_back($time);
    end
    if (done_o) begin
      done_cnt++;
      done_ok = res_valid_o && (res_col_o == 2'd3) && !busy_o;
    end
  end

  logic [3:0] code_tbl [12];

  task automatic do_start(input logic ld, input logic [15:0] rows);
    start_i = 1'b1; load_i = ld; rows_i = rows;
    @(posedge clk); #1;
    start_i = 1'b0; load_i = 1'b0; rows_i = '0;
  endtask

  task automatic load_lut(output bit ok);
    int beat = 0, guard = 0; bit hs;
    lut_valid_i = 1'b1; lut_data_i = '0;
    while (beat < 256 && guard < 2000) begin
      @(negedge clk); hs = lut_ready_o;
      @(posedge clk); #1; guard++;
      if (hs) beat++;
      lut_data_i = 16'(beat);
    end
    lut_valid_i = 1'b0; lut_data_i = '0;
    ok = (beat == 256);
  endtask

  task automatic send_codes(input int n, input bit toggle, output bit ok);
    int idx = 0, guard = 0; bit hs; bit ph = 1'b1;
    while (idx < n && guard < 2000) begin
      code_valid_i = toggle ? ph : 1'b1;
      code_i = code_tbl[idx];
      @(negedge clk); hs = code_ready_o && code_valid_i;
      @(posedge clk); #1; guard++; ph = !ph;
      if (hs) idx++;
    end
    code_valid_i = 1'b0; code_i = '0;
    ok = (idx == n);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int g = 0;
    do begin @(negedge clk); g++; end while (busy_o && g < budget);
    ok = !busy_o;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic [87:0] seen = '0;
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (all_outs !== '0) begin failures++; $display("FAIL reset_hold outs=%h required 0", all_outs); end
    @(posedge clk); #1; rst_i = 1'b0;
    repeat (10) begin @(negedge clk); seen = seen | all_outs; end
    checks++;
    if (seen !== '0) begin failures++; $display("FAIL reset_idle outs=%h required 0", seen); end
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy busy=%b required 0", busy_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_load_one_row;
    bit ok; int rb = r_data.size(); int wb = wr_cnt; int db = done_cnt; int eb = emit_t.size();
    logic [31:0] exp_d [4] = '{32'd121, 32'd377, 32'd633, 32'd889};
    logic [3:0]  exp_k [4] = '{4'd3, 4'd0, 4'd15, 4'd7};
    do_start(1'b1, 16'd1);
    load_lut(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL load_stream accepted<256 beats required 256"); end
    checks++;
    if (wr_cnt - wb != 256) begin failures++; $display("FAIL load_writes got=%0d required 256", wr_cnt - wb); end
    checks++;
    if ({last_m, last_waddr, last_wdata} !== {2'd3, 6'd63, 16'd255}) begin
      failures++; $display("FAIL load_last m=%0d waddr=%0d data=%0d required 3/63/255", last_m, last_waddr, last_wdata);
    end
    code_tbl[0] = 4'd3; code_tbl[1] = 4'd0; code_tbl[2] = 4'd15; code_tbl[3] = 4'd7;
    send_codes(4, 1'b0, ok);
    wait_idle(100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL row1_timeout busy=%b required 0", busy_o); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (iss_c[i] !== 2'(i) || iss_k[i] !== exp_k[i]) begin
        failures++; $display("FAIL issue_%0d c=%0d k=%0d required c=%0d k=%0d", i, iss_c[i], iss_k[i], i, exp_k[i]);
      end
    end
    checks++;
    if (r_data.size() - rb != 4) begin failures++; $display("FAIL row1_count got=%0d required 4", r_data.size() - rb); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (r_row[rb+i] !== 16'd0 || r_col[rb+i] !== 2'(i) || r_data[rb+i] !== exp_d[i]) begin
          failures++;
          $display("FAIL row1_res_%0d row=%0d col=%0d data=%0d required 0/%0d/%0d", i, r_row[rb+i], r_col[rb+i], r_data[rb+i], i, exp_d[i]);
        end
        checks++;
        if (r_t[rb+i] - emit_t[eb+i] != 10) begin
          failures++; $display("FAIL row1_latency_%0d delay=%0d required 10", i, r_t[rb+i] - emit_t[eb+i]);
        end
      end
    end
    checks++;
    if (done_cnt - db != 1 || !done_ok) begin
      failures++; $display("FAIL row1_done pulses=%0d with_last=%0b required 1/1", done_cnt - db, done_ok);
    end
  endtask

  task automatic test_multi_row_toggle;
    bit ok; int rb = r_data.size(); int db = done_cnt;
    int base [3] = '{106, 122, 96};
    code_tbl = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0};
    do_start(1'b0, 16'd3);
    send_codes(12, 1'b1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rows3_codes not all accepted required 12"); end
    wait_idle(200, ok);
    checks++;
    if (r_data.size() - rb != 12) begin failures++; $display("FAIL rows3_count got=%0d required 12", r_data.size() - rb); end
    else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (r_row[rb+i] !== 16'(i / 4) || r_col[rb+i] !== 2'(i % 4) ||
            r_data[rb+i] !== 32'(base[i/4] + 256 * (i % 4))) begin
          failures++;
          $display("FAIL rows3_res_%0d row=%0d col=%0d data=%0d required %0d/%0d/%0d", i, r_row[rb+i], r_col[rb+i],
                   r_data[rb+i], i / 4, i % 4, base[i/4] + 256 * (i % 4));
        end
      end
    end
    checks++;
    if (err_o !== 1'b0 || done_cnt - db != 1) begin
      failures++; $display("FAIL rows3_status err=%b done=%0d required 0/1", err_o, done_cnt - db);
    end
  endtask

  task automatic test_zero_rows;
    int wb = wr_cnt; int cb = rdy_cnt; int db = done_cnt;
    start_i = 1'b1; load_i = 1'b1; rows_i = 16'd0;
    @(posedge clk); #1; start_i = 1'b0; load_i = 1'b0;
    @(negedge clk);
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++; $display("FAIL zero_done done=%b busy=%b required 1/0", done_o, busy_o);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt - db != 1 || wr_cnt != wb || rdy_cnt != cb) begin
      failures++; $display("FAIL zero_quiet done=%0d writes=%0d ready=%0d required 1/0/0", done_cnt - db, wr_cnt - wb, rdy_cnt - cb);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout;
    bit ok; int db = done_cnt; int hb = dec_hi_cnt; int rb = r_data.size();
    suppress = 1'b1;
    code_tbl[0] = 4'd1; code_tbl[1] = 4'd1; code_tbl[2] = 4'd1; code_tbl[3] = 4'd1;
    do_start(1'b0, 16'd1);
    send_codes(4, 1'b0, ok);
    wait_idle(300, ok);
    checks++;
    if (!ok || err_o !== 1'b1) begin failures++; $display("FAIL timeout_abort idle=%b err=%b required 1/1", ok, err_o); end
    checks++;
    if (dec_hi_cnt - hb != 68) begin failures++; $display("FAIL timeout_len decoder_cycles=%0d required 68", dec_hi_cnt - hb); end
    checks++;
    if (done_cnt != db || r_data.size() != rb) begin
      failures++; $display("FAIL timeout_silent done=%0d results=%0d required 0/0", done_cnt - db, r_data.size() - rb);
    end
    suppress = 1'b0;
    do_start(1'b0, 16'd0);
    @(negedge clk);
    checks++;
    if (err_o !== 1'b0) begin failures++; $display("FAIL timeout_clear err=%b required 0", err_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_issue;
    bit ok; int g = 0; int rb = r_data.size(); int db = done_cnt;
    code_tbl[0] = 4'd9; code_tbl[1] = 4'd9; code_tbl[2] = 4'd9; code_tbl[3] = 4'd9;
    do_start(1'b0, 16'd1);
    send_codes(4, 1'b0, ok);
    do begin @(negedge clk); g++; end while (!(dec_decoder_o && dec_c_addr_o == 2'd2) && g < 20);
    checks++;
    if (!(dec_decoder_o && dec_c_addr_o == 2'd2)) begin failures++; $display("FAIL rst_issue_reach c=%0d required 2", dec_c_addr_o); end
    rst_i = 1'b1;
    @(negedge clk);
    checks++;
    if (all_outs !== '0) begin failures++; $display("FAIL rst_issue_outs outs=%h required 0", all_outs); end
    rst_i = 1'b0;
    @(posedge clk); #1;
    do_start(1'b1, 16'd1);
    load_lut(ok);
    code_tbl[0] = 4'd3; code_tbl[1] = 4'd0; code_tbl[2] = 4'd15; code_tbl[3] = 4'd7;
    send_codes(4, 1'b0, ok);
    wait_idle(100, ok);
    checks++;
    if (r_data.size() - rb != 4 || done_cnt - db != 1) begin
      failures++; $display("FAIL rst_rerun results=%0d done=%0d required 4/1", r_data.size() - rb, done_cnt - db);
    end else begin
      checks++;
      if ({r_data[rb], r_data[rb+3]} !== {32'd121, 32'd889}) begin
        failures++; $display("FAIL rst_rerun_data first=%0d last=%0d required 121/889", r_data[rb], r_data[rb+3]);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; load_i = 1'b0; rows_i = '0;
    lut_valid_i = 1'b0; lut_data_i = '0; code_valid_i = 1'b0; code_i = '0;
    test_reset();
    test_load_one_row();
    test_multi_row_toggle();
    test_zero_rows();
    test_timeout();
    test_reset_in_issue();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
